pair_judge: RTL and testbench
=============================

Name: pair_judge

Overview:
- Rules engine for the 4x4 memory-pairs board.
- Consumes the card-select requests that the board/cursor logic emits, i.e. a select pulse plus the cell index under the cursor.
- Flips cards, compares each pair, and holds both cards visible for a fixed time.
- Then marks the pair matched or hides it again, and keeps per-player scores, turn and game-over status for the display path.

Parameters:
- NCELLS, 16: number of board cells; fixed 4x4 board.
- VAL_W, 4: card value width.
- REVEAL_CYCLES, 4: cycles both selected cards stay revealed before resolution. Must be >=1. Set large on the board, 4 in simulation.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- card_vals  in  NCELLS*VAL_W  flattened board values; cell i is bits [i*VAL_W +: VAL_W].
- sel_valid  in  1  one-cycle select request.
- sel_idx  in  4  cell index of the request, 0..15.
- sel_ready  out  1  high when a request can be accepted.
- reject_pulse  out  1  one cycle; a request was presented while ready but was illegal.
- revealed  out  NCELLS  cells currently face-up and not yet matched.
- matched  out  NCELLS  cells permanently matched.
- match_pulse  out  1  one cycle on a pair resolving as a match.
- miss_pulse  out  1  one cycle on a pair resolving as a miss.
- player  out  1  current player, 0 or 1.
- score_p0  out  4  pairs won by player 0.
- score_p1  out  4  pairs won by player 1.
- game_over  out  1  all cells matched.

Behaviour:
- Reset: synchronous, active-high. On the next edge all outputs are 0 except sel_ready=1; FSM goes to IDLE and the timer is cleared. Reset wins over every other event, including mid-HOLD.
- All outputs are registered.
- FSM states: IDLE, ONE, HOLD, DONE.
- Acceptance: a request is accepted only when sel_valid && sel_ready. sel_ready=1 in IDLE and ONE, 0 in HOLD and DONE. Requests while not ready are dropped silently, with no reject_pulse.
- Illegal request: sel_idx is already matched, or equals the first card while in ONE.
  - reject_pulse is high the following cycle.
  - No other state changes; the FSM stays in its current state.
- IDLE, legal request at edge T:
  - first index and its card value are latched from card_vals;
  - revealed[idx]=1 from T+1;
  - next state is ONE.
- ONE, legal request at edge T:
  - second index and value are latched; later changes on card_vals are ignored;
  - revealed gains the second bit from T+1;
  - next state is HOLD and the timer loads REVEAL_CYCLES-1.
- HOLD: both revealed bits stay high for cycles T+1 .. T+REVEAL_CYCLES. At the edge ending cycle T+REVEAL_CYCLES, the pair resolves; the results below are visible in cycle T+REVEAL_CYCLES+1.
  - Both bits in revealed are cleared.
  - On a match (latched values equal): both bits are set in matched; the current player's score increments; player is unchanged; match_pulse is high for that one cycle.
  - On a miss: player toggles; scores unchanged; miss_pulse is high for that one cycle.
  - Next state is IDLE, so sel_ready=1 in the same cycle. If matched becomes all ones, next state is DONE instead.
- DONE:
  - game_over=1 and sel_ready=0;
  - all other outputs hold;
  - only rst exits.
- Width rules:
  - Scores never exceed 8, since there are 8 pairs; 4-bit counters need no saturation.
  - The timer is a $clog2(REVEAL_CYCLES)+1-bit down-counter.
- Invariants:
  - revealed & matched == 0 always.
  - popcount(revealed) <= 2.
  - score_p0 + score_p1 == popcount(matched)/2.
- sel_valid held high for several cycles in IDLE/ONE is treated as repeated requests. Each accepted cycle is evaluated against the updated state, so a held select on the first card rejects on its second cycle.

Decomposition:
- Package pair_judge_pkg holds:
  - typedef enum logic [1:0] {IDLE, ONE, HOLD, DONE} judge_state_t;
  - localparams NCELLS=16, VAL_W=4, IDX_W=4;
  - function card_at(vals, idx) that slices a card value.
- One natural sub-module, reveal_timer: a loadable down-counter with load, value, and a done flag at 0, using synchronous reset.
- Everything else lives in pair_judge.

Test Plan:
- Bench setting: REVEAL_CYCLES=4 and card_vals with cell i = i>>1, so pairs are (0,1), (2,3), ..., (14,15).
- Reset: hold rst=1 for 2 cycles -> revealed=0, matched=0, scores=0, player=0, sel_ready=1, game_over=0.
- Match: select 0 at T0, select 1 at T1 -> revealed=16'h0001 from T0+1 and 16'h0003 during T1+1..T1+4. At T1+5: revealed=0, matched=16'h0003, score_p0=1, player=0, match_pulse for 1 cycle, sel_ready=1.
- Miss: then select 2 and 4 -> revealed=16'h0014 for 4 cycles; then revealed=0, matched still 16'h0003, player=1, miss_pulse for 1 cycle, scores unchanged.
- Rejects and ignores:
  - select 0 (already matched) -> reject_pulse, no state change;
  - select 6 then 6 -> second is rejected, revealed stays 16'h0040, FSM still accepts 7;
  - sel_valid during HOLD -> no effect, no reject_pulse.
- Full game: play all 8 pairs with mixed misses -> game_over=1 after the last resolve, matched=16'hFFFF, score_p0+score_p1=8, sel_ready=0; further selects are ignored.
- Reset mid-HOLD: assert rst in cycle T1+2 of a pair -> next cycle all outputs are at reset values; a new first select is accepted immediately after.

Source files
------------

// File: rtl/pair_judge_pkg.sv
// Shared types, board geometry and the card-slicing helper for the memory-pairs rules engine.
package pair_judge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } judge_state_t;

    localparam int NCELLS = 16;
    localparam int VAL_W  = 4;
    localparam int IDX_W  = 4;

    function automatic logic [VAL_W-1:0] card_at(
        input logic [NCELLS*VAL_W-1:0] vals,
        input logic [IDX_W-1:0]        idx
    );
        card_at = vals[idx*VAL_W +: VAL_W];
    endfunction

endpackage

// File: rtl/pair_judge_reveal_timer.sv
// Loadable down-counter that times how long a revealed pair stays face-up.
module reveal_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_r;

    // Count register: load wins over decrement, and the count parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == {W{1'b0}});

endmodule

// File: rtl/pair_judge.sv
// Rules engine for the 4x4 memory-pairs board: flips cards, judges pairs,
// tracks scores, turn and game-over for the display path.
module pair_judge
    import pair_judge_pkg::*;
#(
    parameter int REVEAL_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCELLS*VAL_W-1:0]   card_vals,
    input  logic                      sel_valid,
    input  logic [IDX_W-1:0]          sel_idx,
    output logic                      sel_ready,
    output logic                      reject_pulse,
    output logic [NCELLS-1:0]         revealed,
    output logic [NCELLS-1:0]         matched,
    output logic                      match_pulse,
    output logic                      miss_pulse,
    output logic                      player,
    output logic [3:0]                score_p0,
    output logic [3:0]                score_p1,
    output logic                      game_over
);

    localparam int TW = $clog2(REVEAL_CYCLES) + 1;
    localparam logic [TW-1:0]     HOLD_LOAD = TW'(REVEAL_CYCLES - 1);
    localparam logic [NCELLS-1:0] CELL_LSB  = {{(NCELLS-1){1'b0}}, 1'b1};

    judge_state_t      state_r, state_s;
    logic [IDX_W-1:0]  first_idx_r, first_idx_s;
    logic [IDX_W-1:0]  second_idx_r, second_idx_s;
    logic [VAL_W-1:0]  first_val_r, first_val_s;
    logic [VAL_W-1:0]  second_val_r, second_val_s;
    logic [NCELLS-1:0] revealed_s, matched_s, pair_mask_s;
    logic [3:0]        score_p0_s, score_p1_s;
    logic              player_s, ready_s, game_over_s;
    logic              reject_s, match_s, miss_s;
    logic              accept_s, illegal_s, timer_load_s, timer_done_s;

    reveal_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load_s),
        .en       (state_r == HOLD),
        .load_val (HOLD_LOAD),
        .done     (timer_done_s)
    );

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_s      = state_r;
        first_idx_s  = first_idx_r;
        first_val_s  = first_val_r;
        second_idx_s = second_idx_r;
        second_val_s = second_val_r;
        revealed_s   = revealed;
        matched_s    = matched;
        score_p0_s   = score_p0;
        score_p1_s   = score_p1;
        player_s     = player;
        reject_s     = 1'b0;
        match_s      = 1'b0;
        miss_s       = 1'b0;
        timer_load_s = 1'b0;
        pair_mask_s  = (CELL_LSB << first_idx_r) | (CELL_LSB << second_idx_r);
        accept_s     = sel_valid && sel_ready;
        illegal_s    = matched[sel_idx] || ((state_r == ONE) && (sel_idx == first_idx_r));

        case (state_r)
            IDLE: begin
                if (accept_s && illegal_s) begin
                    reject_s = 1'b1;
                end else if (accept_s) begin
                    first_idx_s = sel_idx;
                    first_val_s = card_at(card_vals, sel_idx);
                    revealed_s  = revealed | (CELL_LSB << sel_idx);
                    state_s     = ONE;
                end else begin
                    state_s = IDLE;
                end
            end
            ONE: begin
                if (accept_s && illegal_s) begin
                    reject_s = 1'b1;
                end else if (accept_s) begin
                    second_idx_s = sel_idx;
                    second_val_s = card_at(card_vals, sel_idx);
                    revealed_s   = revealed | (CELL_LSB << sel_idx);
                    timer_load_s = 1'b1;
                    state_s      = HOLD;
                end else begin
                    state_s = ONE;
                end
            end
            HOLD: begin
                if (timer_done_s) begin
                    revealed_s = {NCELLS{1'b0}};
                    if (first_val_r == second_val_r) begin
                        matched_s = matched | pair_mask_s;
                        match_s   = 1'b1;
                        if (player) begin
                            score_p1_s = score_p1 + 4'd1;
                        end else begin
                            score_p0_s = score_p0 + 4'd1;
                        end
                    end else begin
                        player_s = ~player;
                        miss_s   = 1'b1;
                    end
                    state_s = (&matched_s) ? DONE : IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            DONE: begin
                state_s = DONE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        ready_s     = (state_s == IDLE) || (state_s == ONE);
        game_over_s = (state_s == DONE);
    end

    // State and output registers; reset returns everything to an empty board.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            first_idx_r  <= {IDX_W{1'b0}};
            first_val_r  <= {VAL_W{1'b0}};
            second_idx_r <= {IDX_W{1'b0}};
            second_val_r <= {VAL_W{1'b0}};
            sel_ready    <= 1'b1;
            reject_pulse <= 1'b0;
            revealed     <= {NCELLS{1'b0}};
            matched      <= {NCELLS{1'b0}};
            match_pulse  <= 1'b0;
            miss_pulse   <= 1'b0;
            player       <= 1'b0;
            score_p0     <= 4'd0;
            score_p1     <= 4'd0;
            game_over    <= 1'b0;
        end else begin
            state_r      <= state_s;
            first_idx_r  <= first_idx_s;
            first_val_r  <= first_val_s;
            second_idx_r <= second_idx_s;
            second_val_r <= second_val_s;
            sel_ready    <= ready_s;
            reject_pulse <= reject_s;
            revealed     <= revealed_s;
            matched      <= matched_s;
            match_pulse  <= match_s;
            miss_pulse   <= miss_s;
            player       <= player_s;
            score_p0     <= score_p0_s;
            score_p1     <= score_p1_s;
            game_over    <= game_over_s;
        end
    end

endmodule

// File: tb/tb_pair_judge.sv
// Directed bench for pair_judge: expected output snapshots are queued as each
// cycle is driven and compared against the DUT one cycle later.
module tb_pair_judge;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] card_vals;
    logic        sel_valid;
    logic [3:0]  sel_idx;
    logic        sel_ready, reject_pulse, match_pulse, miss_pulse, player, game_over;
    logic [15:0] revealed, matched;
    logic [3:0]  score_p0, score_p1;

    typedef struct packed {
        logic        rdy;
        logic        rej;
        logic [15:0] rev;
        logic [15:0] mat;
        logic        mp;
        logic        xp;
        logic        pl;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic        go;
    } snap_t;

    snap_t sb[$];
    snap_t e;
    int    n_tests = 0;
    int    n_fail  = 0;

    pair_judge #(.REVEAL_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .card_vals    (card_vals),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx),
        .sel_ready    (sel_ready),
        .reject_pulse (reject_pulse),
        .revealed     (revealed),
        .matched      (matched),
        .match_pulse  (match_pulse),
        .miss_pulse   (miss_pulse),
        .player       (player),
        .score_p0     (score_p0),
        .score_p1     (score_p1),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    task automatic set_reset_expect();
        e = '0;
        e.rdy = 1'b1;
    endtask

    // Drive one cycle, queue the expected post-edge outputs, then compare.
    task automatic tick(input string tag, input logic v, input logic [3:0] idx);
        snap_t got;
        snap_t want;
        @(negedge clk);
        sel_valid = v;
        sel_idx   = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got  = '{sel_ready, reject_pulse, revealed, matched, match_pulse, miss_pulse,
                 player, score_p0, score_p1, game_over};
        want = sb.pop_front();
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
        e.rej = 1'b0;
        e.mp  = 1'b0;
        e.xp  = 1'b0;
    endtask

    task automatic hold_resolve(input string tag, input int a, input int b, input logic vd);
        for (int k = 0; k < 3; k++) begin
            tick({tag, "_hold"}, vd, 4'(a));
        end
        e.rev = 16'h0000;
        if ((a >> 1) == (b >> 1)) begin
            e.mat = e.mat | (16'h0001 << a) | (16'h0001 << b);
            e.mp  = 1'b1;
            if (e.pl) e.s1 = e.s1 + 4'd1;
            else      e.s0 = e.s0 + 4'd1;
        end else begin
            e.pl = ~e.pl;
            e.xp = 1'b1;
        end
        e.go  = (e.mat == 16'hFFFF);
        e.rdy = ~e.go;
        tick({tag, "_resolve"}, 1'b0, 4'd0);
    endtask

    task automatic play(input string tag, input int a, input int b);
        e.rev = e.rev | (16'h0001 << a);
        e.rdy = 1'b1;
        tick({tag, "_first"}, 1'b1, 4'(a));
        e.rev = e.rev | (16'h0001 << b);
        e.rdy = 1'b0;
        tick({tag, "_second"}, 1'b1, 4'(b));
        hold_resolve(tag, a, b, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        sel_valid = 1'b0;
        sel_idx   = 4'd0;
        for (int i = 0; i < 16; i++) card_vals[i*4 +: 4] = 4'(i >> 1);

        set_reset_expect();
        tick("reset1", 1'b0, 4'd0);
        tick("reset2", 1'b0, 4'd0);
        rst = 1'b0;

        // First pair: the second card's value changes after latching and must be ignored.
        e.rev = 16'h0001;
        tick("match_sel0", 1'b1, 4'd0);
        e.rev = 16'h0003;
        e.rdy = 1'b0;
        tick("match_sel1", 1'b1, 4'd1);
        card_vals[7:4] = 4'hF;
        hold_resolve("match01", 0, 1, 1'b0);
        card_vals[7:4] = 4'h0;
        tick("match_pulse_clear", 1'b0, 4'd0);

        play("miss24", 2, 4);

        e.rej = 1'b1;
        tick("rej_matched", 1'b1, 4'd0);
        tick("rej_clear", 1'b0, 4'd0);

        e.rev = 16'h0040;
        tick("sel6", 1'b1, 4'd6);
        e.rej = 1'b1;
        tick("rej_same6", 1'b1, 4'd6);
        e.rev = 16'h00C0;
        e.rdy = 1'b0;
        tick("sel7", 1'b1, 4'd7);
        hold_resolve("hold_ignore67", 6, 7, 1'b1);

        play("miss8_10", 8, 10);
        play("p23", 2, 3);
        play("p45", 4, 5);
        play("p89", 8, 9);
        play("p1011", 10, 11);
        play("p1213", 12, 13);
        play("p1415", 14, 15);

        tick("done_ignore0", 1'b1, 4'd0);
        tick("done_ignore3", 1'b1, 4'd3);

        rst = 1'b1;
        set_reset_expect();
        tick("reset_from_done", 1'b0, 4'd0);
        rst = 1'b0;

        e.rev = 16'h0001;
        tick("mid_sel0", 1'b1, 4'd0);
        e.rev = 16'h0003;
        e.rdy = 1'b0;
        tick("mid_sel1", 1'b1, 4'd1);
        tick("mid_hold", 1'b0, 4'd0);
        rst = 1'b1;
        set_reset_expect();
        tick("mid_reset", 1'b0, 4'd0);
        rst = 1'b0;
        play("after_reset54", 5, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
